cmd_rcv: RTL

//  Device-side command framer; downstream of the host command sender across the UART link.

---
 rtl/cmd_rcv_pkg.sv | 18 +
 rtl/rx_timeout_tmr.sv | 29 ++
 rtl/cmd_rcv.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cmd_rcv_pkg.sv
// Shared types and default byte constants for the cmd_rcv command framer.
package cmd_rcv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        READY   = 3'd2,
        RESP    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam int         MAX_BYTES_DEF   = 8;
    localparam int         TIMEOUT_CYC_DEF = 500000;
    localparam logic [7:0] TERM_BYTE_DEF   = 8'h0D;
    localparam logic [7:0] ACK_BYTE_DEF    = 8'h0A;
    localparam logic [7:0] NAK_BYTE_DEF    = 8'h15;

endpackage

// File: rtl/rx_timeout_tmr.sv
// Inter-byte timer: counts enabled cycles since the last clear and flags expiry at CYC-1.
module rx_timeout_tmr #(
    parameter int CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

    logic [W-1:0] cnt_q;

    assign expired = enable && (cnt_q == W'(CYC - 1));

    // NOTE: state registers use non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_rcv.sv
// Device-side UART command framer: opcode, payload, terminator -> command; replies ACK/NAK.
// Optional trailing-checksum validation is enabled by defining CMD_CHECKSUM_EN.
module cmd_rcv
    import cmd_rcv_pkg::*;
#(
    parameter int         MAX_BYTES   = MAX_BYTES_DEF,
    parameter logic [7:0] TERM_BYTE   = TERM_BYTE_DEF,
    parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_rdy,
    input  logic [7:0]                 rx_data,
    output logic                       clr_rx_rdy,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       cmd_rdy,
    output logic [7:0]                 cmd_op,
    output logic [8*(MAX_BYTES-1)-1:0] cmd_payload,
    output logic [3:0]                 cmd_len,
    input  logic                       cmd_done,
    output logic                       frm_err
);

    localparam int         PW   = 8 * (MAX_BYTES - 1);
    localparam logic [3:0] LAST = 4'(MAX_BYTES - 1);

    state_t          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      len_q, len_d;
    logic            rdy_q, rdy_d;
    logic [7:0]      tx_q, tx_d;
    logic            err_q, err_d;
    logic            trmt_q, trmt_d;
    logic            tmr_expired;
`ifdef CMD_CHECKSUM_EN
    // The newest data byte is held back until the next one proves it is not the checksum.
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      pend_q, pend_d;
    logic            has_pend_q, has_pend_d;
`endif

    assign clr_rx_rdy  = rx_rdy;
    assign trmt        = trmt_q;
    assign tx_data     = tx_q;
    assign cmd_rdy     = rdy_q;
    assign cmd_op      = op_q;
    assign cmd_payload = pay_q;
    assign cmd_len     = len_q;
    assign frm_err     = err_q;

    rx_timeout_tmr #(.CYC(TIMEOUT_CYC)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state_q != COLLECT) || rx_rdy),
        .enable  (state_q == COLLECT),
        .expired (tmr_expired)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rdy_d   = rdy_q;
        tx_d    = tx_q;
        err_d   = 1'b0;
        trmt_d  = 1'b0;
`ifdef CMD_CHECKSUM_EN
        sum_d      = sum_q;
        pend_d     = pend_q;
        has_pend_d = has_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_rdy && (rx_data != TERM_BYTE)) begin
                    op_d    = rx_data;
                    pay_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
`ifdef CMD_CHECKSUM_EN
                    sum_d      = rx_data;
                    has_pend_d = 1'b0;
`endif
                end
            end
            COLLECT: begin
                if (rx_rdy && (rx_data == TERM_BYTE)) begin
`ifdef CMD_CHECKSUM_EN
                    if (!has_pend_q || (sum_q != 8'h00)) begin
                        err_d   = 1'b1;
                        tx_d    = NAK_BYTE;
                        state_d = RESP;
                    end else begin
                        len_d   = cnt_q;
                        rdy_d   = 1'b1;
                        state_d = READY;
                    end
`else
                    len_d   = cnt_q;
                    rdy_d   = 1'b1;
                    state_d = READY;
`endif
                end else if (rx_rdy) begin
`ifdef CMD_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
                    pend_d     = rx_data;
                    has_pend_d = 1'b1;
                    if (has_pend_q) begin
                        if (cnt_q == LAST) begin
                            err_d   = 1'b1;
                            tx_d    = NAK_BYTE;
                            state_d = RESP;
                        end else begin
                            pay_d[{cnt_q, 3'b000} +: 8] = pend_q;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`else
                    if (cnt_q == LAST) begin
                        err_d   = 1'b1;
                        tx_d    = NAK_BYTE;
                        state_d = RESP;
                    end else begin
                        pay_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            READY: begin
                if (cmd_done) begin
                    rdy_d   = 1'b0;
                    tx_d    = ACK_BYTE;
                    state_d = RESP;
                end
            end
            RESP: begin
                trmt_d  = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            pay_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            rdy_q   <= 1'b0;
            tx_q    <= '0;
            err_q   <= 1'b0;
            trmt_q  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            sum_q      <= '0;
            pend_q     <= '0;
            has_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rdy_q   <= rdy_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            trmt_q  <= trmt_d;
`ifdef CMD_CHECKSUM_EN
            sum_q      <= sum_d;
            pend_q     <= pend_d;
            has_pend_q <= has_pend_d;
`endif
        end
    end

endmodule
